cacheline_burst_arbiter: RTL and testbench

Parametrised successor to the single-port cache-line/DRAM adaptor. Serves NCH cache-side line requesters (e.g. ch0 = I-cache, ch1 = D-cache) through one burst memory port, with round-robin arbitration, configurable line/burst width, and a `bmem_ready` handshake on request and write beats. It sits between the cache arrays and the burst memory model or controller.

---
 rtl/cacheline_burst_arbiter_if.sv | 36 +++
 rtl/cacheline_burst_arbiter.sv | 147 ++++++++++++++
 tb/tb_cacheline_burst_arbiter.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cacheline_burst_arbiter_if.sv
// Bundle of the cache-side line ports and the burst-memory port served by
// cacheline_burst_arbiter. "slave" is the arbiter's view; "master" is the caches plus memory.
interface cacheline_burst_arbiter_if #(
    parameter int LINE_W  = 256,
    parameter int BURST_W = 64,
    parameter int NCH     = 2
);
    logic [NCH-1:0][31:0]     dfp_addr;
    logic [NCH-1:0]           dfp_read;
    logic [NCH-1:0]           dfp_write;
    logic [NCH-1:0][LINE_W-1:0] dfp_wdata;
    logic [LINE_W-1:0]        dfp_rdata;
    logic [NCH-1:0]           dfp_resp;

    logic [31:0]              bmem_addr;
    logic                     bmem_read;
    logic                     bmem_write;
    logic [BURST_W-1:0]       bmem_wdata;
    logic                     bmem_ready;
    logic [BURST_W-1:0]       bmem_rdata;
    logic                     bmem_rvalid;

    modport slave (
        input  dfp_addr, dfp_read, dfp_write, dfp_wdata,
        output dfp_rdata, dfp_resp,
        output bmem_addr, bmem_read, bmem_write, bmem_wdata,
        input  bmem_ready, bmem_rdata, bmem_rvalid
    );

    modport master (
        output dfp_addr, dfp_read, dfp_write, dfp_wdata,
        input  dfp_rdata, dfp_resp,
        input  bmem_addr, bmem_read, bmem_write, bmem_wdata,
        output bmem_ready, bmem_rdata, bmem_rvalid
    );
endinterface

// File: rtl/cacheline_burst_arbiter.sv
// Round-robin arbiter that turns whole cache-line reads/writes from NCH channels
// into BEATS-long bursts on one burst memory port.
module cacheline_burst_arbiter #(
    parameter int LINE_W  = 256,
    parameter int BURST_W = 64,
    parameter int NCH     = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    cacheline_burst_arbiter_if.slave   bus
);
    localparam int BEATS = LINE_W / BURST_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PTR_W = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [2:0] {IDLE, RD_REQ, RD_DATA, WR_DATA, DONE} state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]   grant_q, grant_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        addr_q, addr_d;
    logic [LINE_W-1:0]  wline_q, wline_d;
    logic [LINE_W-1:0]  line_q, line_d;

    logic [NCH-1:0]     pending;
    logic [BURST_W-1:0] wbeat [BEATS];
    logic               found;
    logic [PTR_W-1:0]   sel;
    logic [PTR_W-1:0]   cand;

    logic               bmem_read_c, bmem_write_c;
    logic [31:0]        bmem_addr_c;
    logic [BURST_W-1:0] bmem_wdata_c;
    logic [NCH-1:0]     dfp_resp_c;

    for (genvar gi = 0; gi < NCH; gi++) begin : g_pending
        assign pending[gi] = bus.dfp_read[gi] | bus.dfp_write[gi];
    end

    for (genvar gi = 0; gi < BEATS; gi++) begin : g_wbeat
        assign wbeat[gi] = wline_q[gi*BURST_W +: BURST_W];
    end

    // First pending channel at or after rr_ptr, wrapping around.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        cand  = '0;
        for (int i = 0; i < NCH; i++) begin
            cand = PTR_W'((int'(rr_ptr_q) + i) % NCH);
            if (!found && pending[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        grant_d      = grant_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        wline_d      = wline_q;
        line_d       = line_q;
        bmem_read_c  = 1'b0;
        bmem_write_c = 1'b0;
        bmem_addr_c  = '0;
        bmem_wdata_c = '0;
        dfp_resp_c   = '0;

        unique case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = sel;
                    addr_d  = bus.dfp_addr[sel];
                    wline_d = bus.dfp_wdata[sel];
                    cnt_d   = '0;
                    state_d = bus.dfp_read[sel] ? RD_REQ : WR_DATA;
                end
            end
            RD_REQ: begin
                bmem_read_c = 1'b1;
                bmem_addr_c = addr_q;
                if (bus.bmem_ready) begin
                    cnt_d   = '0;
                    state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                if (bus.bmem_rvalid) begin
                    line_d[cnt_q*BURST_W +: BURST_W] = bus.bmem_rdata;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(BEATS - 1)) begin
                        state_d = DONE;
                    end
                end
            end
            WR_DATA: begin
                bmem_write_c = 1'b1;
                bmem_addr_c  = addr_q;
                bmem_wdata_c = wbeat[cnt_q];
                if (bus.bmem_ready) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(BEATS - 1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                dfp_resp_c[grant_q] = 1'b1;
                rr_ptr_d = (grant_q == PTR_W'(NCH - 1)) ? '0 : grant_q + 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            cnt_q    <= '0;
            addr_q   <= '0;
            wline_q  <= '0;
            line_q   <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wline_q  <= wline_d;
            line_q   <= line_d;
        end
    end

    assign bus.bmem_read  = bmem_read_c;
    assign bus.bmem_write = bmem_write_c;
    assign bus.bmem_addr  = bmem_addr_c;
    assign bus.bmem_wdata = bmem_wdata_c;
    assign bus.dfp_resp   = dfp_resp_c;
    // The line buffer only changes in RD_DATA, so it doubles as the stable read result.
    assign bus.dfp_rdata  = line_q;
endmodule

// File: tb/tb_cacheline_burst_arbiter.sv
// Directed bench for cacheline_burst_arbiter: default 2-channel/4-beat instance
// plus a 3-channel/8-beat instance.
module tb_cacheline_burst_arbiter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cacheline_burst_arbiter_if #(.LINE_W(256), .BURST_W(64), .NCH(2)) bus ();
    cacheline_burst_arbiter_if #(.LINE_W(512), .BURST_W(64), .NCH(3)) bus3 ();

    cacheline_burst_arbiter #(.LINE_W(256), .BURST_W(64), .NCH(2)) u_dut (
        .clk (clk), .rst (rst), .bus (bus)
    );
    cacheline_burst_arbiter #(.LINE_W(512), .BURST_W(64), .NCH(3)) u_dut3 (
        .clk (clk), .rst (rst), .bus (bus3)
    );

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [255:0] L_RD = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                     64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    localparam logic [255:0] L_WR = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                                     64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
    localparam logic [255:0] L_GAP = {64'h1357_9BDF_2468_ACE0, 64'h0F0F_0F0F_F0F0_F0F0,
                                      64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pat(input int k);
        return 64'(k) * 64'h0101_0101_0101_0101;
    endfunction

    // Full read on the default instance with ready and rvalid always high.
    task automatic run_read(input int ch, input logic [31:0] addr,
                            input logic [255:0] line, input string tag);
        logic [1:0] exp_resp;
        exp_resp = 2'b01 << ch;
        bus.dfp_addr[ch] = addr;
        bus.dfp_read[ch] = 1'b1;
        bus.bmem_ready   = 1'b1;
        bus.bmem_rvalid  = 1'b0;
        tick();
        chk({tag, "_req"}, bus.bmem_read, 1'b1);
        chk({tag, "_addr"}, bus.bmem_addr, addr);
        chk({tag, "_early0"}, bus.dfp_resp, 2'b00);
        tick();
        chk({tag, "_req_drop"}, bus.bmem_read, 1'b0);
        for (int b = 0; b < 4; b++) begin
            bus.bmem_rdata  = line[b*64 +: 64];
            bus.bmem_rvalid = 1'b1;
            tick();
            if (b < 3) chk({tag, "_early"}, bus.dfp_resp, 2'b00);
        end
        chk({tag, "_resp"}, bus.dfp_resp, exp_resp);
        chk({tag, "_line"}, bus.dfp_rdata, line);
        bus.dfp_read[ch] = 1'b0;
        bus.bmem_rvalid  = 1'b0;
        tick();
        chk({tag, "_resp_pulse"}, bus.dfp_resp, 2'b00);
    endtask

    initial begin
        logic [1:0]   served;
        logic [2:0]   served3;
        logic [2:0]   exp3 [3];
        logic [511:0] exp512;
        logic [511:0] wl512;
        bit           got;

        rst = 1'b1;
        bus.dfp_addr = '0;  bus.dfp_read = '0;  bus.dfp_write = '0;  bus.dfp_wdata = '0;
        bus.bmem_ready = 1'b0;  bus.bmem_rdata = '0;  bus.bmem_rvalid = 1'b0;
        bus3.dfp_addr = '0; bus3.dfp_read = '0; bus3.dfp_write = '0; bus3.dfp_wdata = '0;
        bus3.bmem_ready = 1'b0; bus3.bmem_rdata = '0; bus3.bmem_rvalid = 1'b0;
        repeat (3) tick();

        chk("rst_bmem_read", bus.bmem_read, 1'b0);
        chk("rst_bmem_write", bus.bmem_write, 1'b0);
        chk("rst_bmem_addr", bus.bmem_addr, 32'h0);
        chk("rst_bmem_wdata", bus.bmem_wdata, 64'h0);
        chk("rst_dfp_resp", bus.dfp_resp, 2'b00);
        chk("rst_dfp_rdata", bus.dfp_rdata, 256'h0);
        rst = 1'b0;
        tick();

        // Single read, ch0: resp on the 7th cycle counting the request cycle.
        run_read(0, 32'h0000_1000, L_RD, "rd1");

        // Write ch1, beat 1 stalled two cycles.
        bus.dfp_addr[1]  = 32'h0000_2040;
        bus.dfp_wdata[1] = L_WR;
        bus.dfp_write[1] = 1'b1;
        bus.bmem_ready   = 1'b1;
        tick();
        chk("wr_valid0", bus.bmem_write, 1'b1);
        chk("wr_beat0", bus.bmem_wdata, 64'hAAAA_AAAA_AAAA_AAAA);
        chk("wr_addr0", bus.bmem_addr, 32'h0000_2040);
        tick();
        bus.bmem_ready = 1'b0;
        chk("wr_beat1a", bus.bmem_wdata, 64'hBBBB_BBBB_BBBB_BBBB);
        tick();
        chk("wr_beat1b", bus.bmem_wdata, 64'hBBBB_BBBB_BBBB_BBBB);
        chk("wr_addr1", bus.bmem_addr, 32'h0000_2040);
        tick();
        chk("wr_beat1c", bus.bmem_wdata, 64'hBBBB_BBBB_BBBB_BBBB);
        chk("wr_no_resp", bus.dfp_resp, 2'b00);
        bus.bmem_ready = 1'b1;
        tick();
        chk("wr_beat2", bus.bmem_wdata, 64'hCCCC_CCCC_CCCC_CCCC);
        tick();
        chk("wr_beat3", bus.bmem_wdata, 64'hDDDD_DDDD_DDDD_DDDD);
        chk("wr_addr3", bus.bmem_addr, 32'h0000_2040);
        tick();
        chk("wr_resp", bus.dfp_resp, 2'b10);
        chk("wr_done_idle", bus.bmem_write, 1'b0);
        bus.dfp_write[1] = 1'b0;
        tick();
        chk("wr_resp_pulse", bus.dfp_resp, 2'b00);
        chk("wr_rdata_stable", bus.dfp_rdata, L_RD);

        // Both channels reading back-to-back for three rounds each.
        bus.bmem_ready  = 1'b1;
        bus.bmem_rvalid = 1'b1;
        bus.bmem_rdata  = 64'h5A5A_5A5A_5A5A_5A5A;
        bus.dfp_read    = 2'b11;
        for (int t = 0; t < 6; t++) begin
            got = 1'b0;
            served = 2'b00;
            for (int c = 0; c < 20 && !got; c++) begin
                tick();
                chk("rr_not_both", bus.dfp_resp == 2'b11, 1'b0);
                if (bus.dfp_resp != 2'b00) begin
                    got = 1'b1;
                    served = bus.dfp_resp;
                end
            end
            chk("rr_resp_seen", got, 1'b1);
            chk($sformatf("rr_grant%0d", t), served, (t % 2 == 0) ? 2'b01 : 2'b10);
            bus.dfp_read = (t == 5) ? 2'b00 : (bus.dfp_read & ~served);
            tick();
            chk("rr_resp_pulse", bus.dfp_resp, 2'b00);
            if (t < 5) bus.dfp_read = 2'b11;
        end
        bus.bmem_rvalid = 1'b0;
        chk("rr_line", bus.dfp_rdata, {4{64'h5A5A_5A5A_5A5A_5A5A}});
        tick();

        // Read with ready delayed and gaps between beats.
        bus.dfp_addr[0] = 32'h0000_3000;
        bus.dfp_read[0] = 1'b1;
        bus.bmem_ready  = 1'b0;
        tick();
        chk("slow_req", bus.bmem_read, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("slow_req_held", bus.bmem_read, 1'b1);
            chk("slow_req_addr", bus.bmem_addr, 32'h0000_3000);
        end
        bus.bmem_ready = 1'b1;
        tick();
        chk("slow_req_drop", bus.bmem_read, 1'b0);
        for (int b = 0; b < 4; b++) begin
            bus.bmem_rvalid = 1'b0;
            bus.bmem_rdata  = 64'hDEAD_BEEF_DEAD_BEEF;
            tick();
            chk("slow_gap_resp", bus.dfp_resp, 2'b00);
            bus.bmem_rvalid = 1'b1;
            bus.bmem_rdata  = L_GAP[b*64 +: 64];
            tick();
        end
        chk("slow_resp", bus.dfp_resp, 2'b01);
        chk("slow_line", bus.dfp_rdata, L_GAP);
        bus.dfp_read[0] = 1'b0;
        bus.bmem_rdata  = 64'hFFFF_0000_FFFF_0000;
        tick();
        tick();
        chk("slow_extra_ignored", bus.dfp_rdata, L_GAP);
        bus.bmem_rvalid = 1'b0;

        // Reset in RD_DATA after two beats.
        bus.dfp_addr[1] = 32'h0000_4000;
        bus.dfp_read[1] = 1'b1;
        bus.bmem_ready  = 1'b1;
        tick();
        tick();
        for (int b = 0; b < 2; b++) begin
            bus.bmem_rdata  = pat(b + 7);
            bus.bmem_rvalid = 1'b1;
            tick();
        end
        rst = 1'b1;
        bus.bmem_rvalid = 1'b0;
        bus.dfp_read    = 2'b00;
        tick();
        chk("abort_bmem_read", bus.bmem_read, 1'b0);
        chk("abort_bmem_write", bus.bmem_write, 1'b0);
        chk("abort_bmem_addr", bus.bmem_addr, 32'h0);
        chk("abort_bmem_wdata", bus.bmem_wdata, 64'h0);
        chk("abort_resp", bus.dfp_resp, 2'b00);
        chk("abort_rdata", bus.dfp_rdata, 256'h0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("abort_no_resp", bus.dfp_resp, 2'b00);
        end
        run_read(1, 32'h0000_4000, L_RD, "rd_after_rst");

        // Wide instance: 8-beat read on ch2.
        exp512 = '0;
        for (int b = 0; b < 8; b++) exp512[b*64 +: 64] = pat(b + 1);
        bus3.dfp_addr[2] = 32'h0000_8000;
        bus3.dfp_read    = 3'b100;
        bus3.bmem_ready  = 1'b1;
        tick();
        chk("w_rd_req", bus3.bmem_read, 1'b1);
        chk("w_rd_addr", bus3.bmem_addr, 32'h0000_8000);
        tick();
        for (int b = 0; b < 8; b++) begin
            bus3.bmem_rdata  = pat(b + 1);
            bus3.bmem_rvalid = 1'b1;
            tick();
        end
        chk("w_rd_resp", bus3.dfp_resp, 3'b100);
        chk("w_rd_line", bus3.dfp_rdata, exp512);
        bus3.dfp_read    = 3'b000;
        bus3.bmem_rvalid = 1'b0;
        tick();
        chk("w_rd_pulse", bus3.dfp_resp, 3'b000);

        // Wide instance: 8-beat write on ch1.
        wl512 = '0;
        for (int b = 0; b < 8; b++) wl512[b*64 +: 64] = pat(b + 17);
        bus3.dfp_addr[1]  = 32'h0000_9000;
        bus3.dfp_wdata[1] = wl512;
        bus3.dfp_write    = 3'b010;
        tick();
        for (int b = 0; b < 8; b++) begin
            chk($sformatf("w_wr_beat%0d", b), bus3.bmem_wdata, pat(b + 17));
            chk("w_wr_valid", bus3.bmem_write, 1'b1);
            tick();
        end
        chk("w_wr_resp", bus3.dfp_resp, 3'b010);
        bus3.dfp_write = 3'b000;
        tick();

        // Wide instance: all three reading; rr_ptr now points at ch2.
        exp3[0] = 3'b100;
        exp3[1] = 3'b001;
        exp3[2] = 3'b010;
        bus3.bmem_rvalid = 1'b1;
        bus3.bmem_rdata  = pat(3);
        bus3.dfp_read    = 3'b111;
        for (int t = 0; t < 3; t++) begin
            got = 1'b0;
            served3 = 3'b000;
            for (int c = 0; c < 20 && !got; c++) begin
                tick();
                chk("w_rr_onehot", $countones(bus3.dfp_resp) <= 1, 1'b1);
                if (bus3.dfp_resp != 3'b000) begin
                    got = 1'b1;
                    served3 = bus3.dfp_resp;
                end
            end
            chk("w_rr_seen", got, 1'b1);
            chk($sformatf("w_rr_grant%0d", t), served3, exp3[t]);
            bus3.dfp_read = (t == 2) ? 3'b000 : (bus3.dfp_read & ~served3);
            tick();
            if (t < 2) bus3.dfp_read = 3'b111;
        end
        bus3.bmem_rvalid = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
